// File: rtl/adder_pkg.sv
// Shared definitions for the chunked adder: FSM state, default geometry and
// the chunk-counter width helper.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CHUNK = 4;

  // Counter must hold 0..nchunk-1 and never collapse to zero bits.
  function automatic int cnt_width(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational W-bit adder slice used once per clock by chunked_adder.
module chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder processing CHUNK bits per clock behind
// valid/ready handshakes. Define ADDER_OVERFLOW_EN to generate signed overflow.
module chunked_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;

  logic [CHUNK-1:0] ca, cb, cs;
  logic             cc;
  logic             last_chunk;
  int               base;

  assign base       = int'(cnt) * CHUNK;
  assign ca         = a_r[base +: CHUNK];
  assign cb         = b_r[base +: CHUNK];
  assign last_chunk = (cnt == LAST);

  chunk_adder #(.W(CHUNK)) u_chunk (
    .a    (ca),
    .b    (cb),
    .cin  (carry),
    .sum  (cs),
    .cout (cc)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order in the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sum_r <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b;
          carry <= cin;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          sum_r[base +: CHUNK] <= cs;
          carry                <= cc;
          if (last_chunk) state <= DONE;
          else            cnt   <= cnt + 1'b1;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The carry register keeps the final chunk carry until the next accept.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign cout      = carry;

`ifdef ADDER_OVERFLOW_EN
  logic ovf_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (state == RUN && last_chunk) begin
      ovf_r <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (cs[CHUNK-1] != a_r[WIDTH-1]);
    end
  end

  assign overflow = ovf_r;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Parametrised multi-cycle adder. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then adds them CHUNK bits per clock with a registered inter-chunk carry. It returns sum, carry-out and, optionally, signed overflow over a second valid/ready handshake. It generalises the single-bit full adder into an area-scalable arithmetic datapath block for the assignment designs.

## Interface
- WIDTH, 8, operand/sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH. NCHUNK = WIDTH/CHUNK.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement overflow (see Configuration).

## Operation
- FSM states:
  - IDLE → RUN on in_valid && in_ready.
  - RUN → DONE after the chunk with index NCHUNK-1 is processed.
  - DONE → IDLE on out_valid && out_ready.
- in_ready = (state == IDLE).
- out_valid = (state == DONE).
- Acceptance latches a, b and cin into internal registers. Input changes after acceptance have no effect.
- RUN:
  - Chunk counter k runs 0..NCHUNK-1.
  - Each cycle, operand bits [k*CHUNK +: CHUNK] are added with the carry register.
  - The result is written into the same slice of the sum register, and the carry register takes the chunk carry-out.
- Counter width is $clog2(NCHUNK), minimum 1 bit. When CHUNK == WIDTH, RUN lasts exactly one cycle.
- cout is the carry register after the final chunk.
- In DONE, sum, cout and overflow are held stable until out_ready.
- in_valid while not IDLE is ignored; it is not queued.
- Reset values:
  - state = IDLE, so in_ready = 1 and out_valid = 0.
  - sum = 0, cout = 0, overflow = 0.
  - Counter and carry register = 0.
- Reset mid-RUN or mid-DONE aborts the operation and discards the result. The first post-reset accept behaves normally.

## Timing
- Accept at edge T. Chunks are processed at edges T+1..T+NCHUNK.
- out_valid is high from edge T+NCHUNK.
- Result handshake at edge R. in_ready is high from R; the next accept is possible at R+1.
- Minimum issue interval: NCHUNK+2 cycles.
- Outputs are registered. There is no combinational path from in_valid or out_ready to any output except through state.

## Configuration
- ADDER_OVERFLOW_EN:
  - Defined: overflow is registered at the final chunk as (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]), using the latched operands. It is valid while out_valid is high.
  - Undefined: overflow is tied to 0 and no overflow logic is generated.

## Structure
- Package adder_pkg:
  - state enum: IDLE, RUN, DONE.
  - Default WIDTH/CHUNK constants.
  - A function returning the chunk-counter width.
- Sub-module chunk_adder:
  - Combinational CHUNK-bit ripple adder with ports a, b, cin, sum, cout.
  - chunked_adder instantiates one and holds all sequential state itself.

## Test plan
Defaults WIDTH=8, CHUNK=4.
1. a=0x0F, b=0x01, cin=0 → sum=0x10, cout=0, overflow=0. out_valid rises 2 edges after the accept edge.
2. a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
3. a=0x7F, b=0x01 → sum=0x80, overflow=1 with ADDER_OVERFLOW_EN, 0 without. a=0x80, b=0x80 → sum=0x00, cout=1, overflow=1 with macro.
4. Hold out_ready=0 for 5 cycles after out_valid with in_valid=1 and new operands:
   - Result stays stable and in_ready stays 0.
   - The new operands are not accepted until the cycle after out_ready=1.
5. Assert rst one cycle into RUN:
   - Outputs go to reset values immediately.
   - After release, a=0x12, b=0x34 → sum=0x46 with no residue from the aborted operation.
6. Sweep WIDTH=8 with CHUNK=1, 2 and 8 on random operands against a+b+cin. out_valid latency must equal NCHUNK edges after accept.
